// File: rtl/execute_unit.sv
// Execute stage fed by the register bank read ports. Single-cycle ALU ops
// (add/sub/logic/shift/compare) complete at the accepting edge; MUL, DIVU and
// REMU iterate WIDTH cycles behind Busy. The result, its address and a
// one-cycle write strobe go back to the register bank write port.
//
// Ports:
//   Clock_in        rising-edge clock
//   Signal_reset_n  asynchronous active-low reset
//   Start           request, accepted only while Busy=0
//   Opcode          operation select (0..12 legal, 13..15 illegal)
//   Operand_1/2     source operands
//   Dest_address    destination register of the request
//   Result          registered result, held between operations
//   Result_address  registered destination of the completed op
//   Result_write    one-cycle write strobe
//   Busy            iterative op in progress
//   Zero            Result == 0, registered alongside Result
//   Illegal         one-cycle pulse for an undefined opcode
module execute_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  Clock_in,
  input  logic                  Signal_reset_n,
  input  logic                  Start,
  input  logic [3:0]            Opcode,
  input  logic [WIDTH-1:0]      Operand_1,
  input  logic [WIDTH-1:0]      Operand_2,
  input  logic [ADDR_WIDTH-1:0] Dest_address,
  output logic [WIDTH-1:0]      Result,
  output logic [ADDR_WIDTH-1:0] Result_address,
  output logic                  Result_write,
  output logic                  Busy,
  output logic                  Zero,
  output logic                  Illegal
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned ShW  = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;
  localparam logic [3:0] OpDivu = 4'd11;
  localparam logic [3:0] OpRemu = 4'd12;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic                  write_q, write_d;
  logic                  zero_q;
  logic                  illegal_q, illegal_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                  rem_sel_q, rem_sel_d;
  // a: multiplicand (MUL) or dividend/quotient shifter (DIV)
  // b: multiplier (MUL) or divisor (DIV)
  // acc: product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      acc_q, acc_d;

  logic [WIDTH-1:0]      alu_res;
  logic [ShW-1:0]        shamt;
  logic [WIDTH-1:0]      mul_acc_nxt;
  logic [WIDTH:0]        rem_shift;
  logic [WIDTH:0]        rem_diff;
  logic [WIDTH-1:0]      rem_nxt;
  logic [WIDTH-1:0]      quo_nxt;
  logic                  last_iter;

  assign shamt = Operand_2[ShW-1:0];

  always_comb begin
    alu_res = '0;
    case (Opcode)
      OpAdd:   alu_res = Operand_1 + Operand_2;
      OpSub:   alu_res = Operand_1 - Operand_2;
      OpAnd:   alu_res = Operand_1 & Operand_2;
      OpOr:    alu_res = Operand_1 | Operand_2;
      OpXor:   alu_res = Operand_1 ^ Operand_2;
      OpSll:   alu_res = Operand_1 << shamt;
      OpSrl:   alu_res = Operand_1 >> shamt;
      OpSra:   alu_res = WIDTH'($signed(Operand_1) >>> shamt);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(Operand_1) < $signed(Operand_2)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, Operand_1 < Operand_2};
      default: alu_res = '0;
    endcase
  end

  // Shift-add multiply step: consume multiplier LSB, shift multiplicand up.
  assign mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);

  // Restoring divide step. A zero divisor never borrows, which naturally
  // yields an all-ones quotient and a remainder equal to the dividend.
  assign rem_shift = {acc_q, a_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};

  always_comb begin
    if (!rem_diff[WIDTH]) begin
      rem_nxt = rem_diff[WIDTH-1:0];
      quo_nxt = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_shift[WIDTH-1:0];
      quo_nxt = {a_q[WIDTH-2:0], 1'b0};
    end
  end

  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    res_addr_d = res_addr_q;
    write_d    = 1'b0;
    illegal_d  = 1'b0;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    rem_sel_d  = rem_sel_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (Opcode <= OpSltu) begin
            result_d   = alu_res;
            res_addr_d = Dest_address;
            write_d    = 1'b1;
          end else if (Opcode <= OpRemu) begin
            a_d       = Operand_1;
            b_d       = Operand_2;
            acc_d     = '0;
            cnt_d     = '0;
            dest_d    = Dest_address;
            rem_sel_d = (Opcode == OpRemu);
            state_d   = (Opcode == OpMul) ? StMul : StDiv;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d = mul_acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          result_d   = mul_acc_nxt;
          res_addr_d = dest_q;
          write_d    = 1'b1;
          state_d    = StIdle;
        end
      end
      StDiv: begin
        acc_d = rem_nxt;
        a_d   = quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          result_d   = rem_sel_q ? rem_nxt : quo_nxt;
          res_addr_d = dest_q;
          write_d    = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock_in or negedge Signal_reset_n) begin
    if (!Signal_reset_n) begin
      state_q    <= StIdle;
      result_q   <= '0;
      res_addr_q <= '0;
      write_q    <= 1'b0;
      zero_q     <= 1'b1;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
      dest_q     <= '0;
      rem_sel_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      res_addr_q <= res_addr_d;
      write_q    <= write_d;
      zero_q     <= (result_d == '0);
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      rem_sel_q  <= rem_sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
    end
  end

  assign Result         = result_q;
  assign Result_address = res_addr_q;
  assign Result_write   = write_q;
  assign Busy           = (state_q != StIdle);
  assign Zero           = zero_q;
  assign Illegal        = illegal_q;

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Execute stage directly downstream of the 16x32 register bank.
- Consumes the two read operands plus decoded opcode and destination address; produces the result, write address and one-cycle write strobe that feed back into the register bank's write port.
- Logic/shift/compare/add ops complete in one cycle; MUL, DIVU and REMU are iterative (WIDTH cycles) behind a Busy handshake.

Parameters:
- WIDTH, 32, operand/result width; also the MUL/DIV iteration count.
- ADDR_WIDTH, 4, register address width (16 registers).

Ports:
- Clock_in  input  1  single clock, rising-edge active.
- Signal_reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled on rising edge; accepted only when Busy=0.
- Opcode  input  4  operation select (map below).
- Operand_1  input  WIDTH  first source (Out_1 of register bank).
- Operand_2  input  WIDTH  second source (Out_2 of register bank).
- Dest_address  input  ADDR_WIDTH  destination register.
- Result  output  WIDTH  registered result.
- Result_address  output  ADDR_WIDTH  registered copy of Dest_address for the accepted op.
- Result_write  output  1  one-cycle write strobe to the register bank.
- Busy  output  1  high while an iterative op is in progress.
- Zero  output  1  Result==0, registered with Result.
- Illegal  output  1  one-cycle pulse for an undefined opcode.

Behaviour:
- Reset (async, Signal_reset_n=0): state IDLE; Result=0, Result_address=0, Result_write=0, Busy=0, Zero=1, Illegal=0; iteration counter and internal accumulators cleared. Reset mid-operation abandons the op with no write strobe.
- Opcode map: 0 ADD, 1 SUB (Op1-Op2), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount Op2[4:0]), 8 SLT signed (result 1/0), 9 SLTU, 10 MUL (low WIDTH bits, unsigned shift-add), 11 DIVU quotient, 12 REMU remainder (restoring division), 13-15 illegal.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- States: IDLE, MUL, DIV.
- IDLE, Start=1, single-cycle opcode (0-9): Result, Result_address and Zero are updated at the accepting edge. Result_write=1 for exactly the next cycle. Busy stays 0. Back-to-back Starts are legal every cycle, giving one write per cycle.
- IDLE, Start=1, opcode 13-15: Illegal=1 for one cycle, Result_write=0, Result unchanged.
- IDLE, Start=1, opcode 10: latch operands and address, go to MUL, Busy=1, counter=0.
- IDLE, Start=1, opcode 11/12: latch operands, address and quotient/remainder select, go to DIV, Busy=1, counter=0.
- MUL/DIV: one iteration per edge. At the WIDTH-th iteration edge, Result/Zero are updated, Result_write=1 for the next cycle, Busy=0, and state returns to IDLE.
  - Accept at edge E0 → write strobe in the cycle after E32 (WIDTH=32).
  - Earliest next accept is E33.
- Start while Busy=1: ignored with no side effects. Operand/opcode changes during MUL/DIV have no effect because all inputs are latched at accept.
- Divide by zero: DIVU result is all ones; REMU result is Op1. Still takes WIDTH cycles; not illegal.
- Dest_address 0 is written like any other register; no hard-wired zero.
- Result holds its value between operations; Result_write is never high for more than one consecutive cycle per accepted op.

Test Plan:
- Reset held low, then released → all outputs at reset values. Start=1, ADD 0x0000_0005+0x0000_0003, Dest=3 → next cycle Result=0x8, Result_address=3, Result_write=1 for 1 cycle, Busy=0.
- Back-to-back SUB 0-1 then SRA 0x8000_0000 by 4 then SLT 0xFFFF_FFFF,1 on consecutive cycles → results 0xFFFF_FFFF, 0xF800_0000, 0x1 on consecutive cycles, each with a 1-cycle strobe.
- MUL 0x0001_0003 x 0x0002_0005, Dest=7, with Start toggled during Busy → Busy high for 32 cycles, single strobe, Result=0x000B_000F, extra Starts ignored.
- DIVU 100/7 then REMU 100/7 → 0xE and 0x2. DIVU 5/0 → 0xFFFF_FFFF. REMU 5/0 → 0x5.
- Opcode 14 with Start → Illegal pulse 1 cycle, no Result_write, Result unchanged.
- Signal_reset_n pulsed low at iteration 10 of a DIVU → outputs clear immediately, no strobe ever issued; a subsequent ADD works normally.
